// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write path.
// Requester ids, buffer states and the write request bundle.
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 2;
  localparam int DATA_WIDTH     = 32;
  localparam int REGISTER_COUNT = 2 ** REG_ADDR_WIDTH;

  typedef logic requester_id_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] register;
    logic [DATA_WIDTH-1:0]     data;
  } write_request_t;

endpackage

// File: rtl/regfile_write_arbiter_write_buffer.sv
// One-entry holding buffer for a single writeback requester.
// A grant and an accept on the same edge replace the entry.
module write_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [REG_ADDR_WIDTH-1:0] in_register,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic                      grant,
  output logic                      full,
  output logic                      accept,
  output logic [REG_ADDR_WIDTH-1:0] out_register,
  output logic [DATA_WIDTH-1:0]     out_data
);
  import regfile_pkg::*;

  buf_state_t                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

  // Ready comes from state and grant only, never from in_valid.
  assign in_ready     = !reset && ((state_q == BUF_EMPTY) || grant);
  assign accept       = in_valid && in_ready;
  assign full         = (state_q == BUF_FULL);
  assign out_register = reg_q;
  assign out_data     = data_q;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    data_d  = data_q;
    if (accept) begin
      state_d = BUF_FULL;
      reg_d   = in_register;
      data_d  = in_data;
    end else if (grant) begin
      state_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port.
// Oldest-first with round-robin tiebreak; registered write port.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req0_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    req0_register,
  input  logic [DATA_WIDTH-1:0]        req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    req1_register,
  input  logic [DATA_WIDTH-1:0]        req1_data,
  output logic                         req1_ready,
  output logic [REG_ADDR_WIDTH-1:0]    write_register,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic                         write_enable,
  output logic [2**REG_ADDR_WIDTH-1:0] pending
);
  import regfile_pkg::*;

  localparam int REG_COUNT = 2 ** REG_ADDR_WIDTH;

  logic [1:0]                full, accept, grant, full_next;
  logic [REG_ADDR_WIDTH-1:0] buf_reg  [2];
  logic [DATA_WIDTH-1:0]     buf_data [2];

  logic          any_grant;
  requester_id_t gid;

  logic                      age_valid_q, age_valid_d;
  requester_id_t             older_q, older_d;
  requester_id_t             ptr_q, ptr_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

  write_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_buf0 (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (req0_valid),
    .in_register (req0_register),
    .in_data     (req0_data),
    .in_ready    (req0_ready),
    .grant       (grant[0]),
    .full        (full[0]),
    .accept      (accept[0]),
    .out_register(buf_reg[0]),
    .out_data    (buf_data[0])
  );

  write_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_buf1 (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (req1_valid),
    .in_register (req1_register),
    .in_data     (req1_data),
    .in_ready    (req1_ready),
    .grant       (grant[1]),
    .full        (full[1]),
    .accept      (accept[1]),
    .out_register(buf_reg[1]),
    .out_data    (buf_data[1])
  );

  always_comb begin
    gid = 1'b0;
    unique case (1'b1)
      (full == 2'b11) && age_valid_q:  gid = older_q;
      (full == 2'b11) && !age_valid_q: gid = ptr_q;
      default:                         gid = full[1];
    endcase
    any_grant = |full;
    grant[0]  = any_grant && (gid == 1'b0);
    grant[1]  = any_grant && (gid == 1'b1);
    full_next = accept | (full & ~grant);
  end

  // A refill (including replace) makes that buffer the younger one.
  always_comb begin
    age_valid_d = age_valid_q;
    older_d     = older_q;
    if (full_next != 2'b11) begin
      age_valid_d = 1'b0;
    end else if (accept == 2'b01) begin
      age_valid_d = 1'b1;
      older_d     = 1'b1;
    end else if (accept == 2'b10) begin
      age_valid_d = 1'b1;
      older_d     = 1'b0;
    end else if (accept == 2'b11) begin
      age_valid_d = 1'b0;
    end
  end

  always_comb begin
    ptr_d   = any_grant ? ~gid : ptr_q;
    we_d    = any_grant;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (any_grant) begin
      wreg_d  = buf_reg[gid];
      wdata_d = buf_data[gid];
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if ((full[0] && buf_reg[0] == REG_ADDR_WIDTH'(r)) ||
          (full[1] && buf_reg[1] == REG_ADDR_WIDTH'(r)) ||
          (we_q && wreg_q == REG_ADDR_WIDTH'(r)))
        pending[r] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      age_valid_q <= 1'b0;
      older_q     <= 1'b0;
      ptr_q       <= 1'b0;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      age_valid_q <= age_valid_d;
      older_q     <= older_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  assign write_enable   = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Scoreboard queue holds writes in the order they must commit.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [1:0]  req0_register = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [1:0]  req1_register = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic [1:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;
  logic [3:0]  pending;

  int tests = 0;
  int fails = 0;
  write_request_t exp_q[$];

  regfile_write_arbiter #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_register (req0_register),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_register (req1_register),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .write_register(write_register),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] r, input logic [31:0] d);
    write_request_t e;
    e.register = r;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  // Every committed write is matched against the scoreboard head.
  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        write_request_t e;
        e = exp_q.pop_front();
        chk("write_register", 64'(write_register), 64'(e.register));
        chk("write_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    @(negedge clock);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_wreg", 64'(write_register), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int i0;
    int i1;

    // Single write, minimum latency and pending window
    do_reset();
    push(2'd2, 32'hDEADBEEF);
    req0_valid    = 1'b1;
    req0_register = 2'd2;
    req0_data     = 32'hDEADBEEF;
    @(negedge clock);
    chk("t1_ready0_c1", 64'(req0_ready), 64'd1);
    chk("t1_pending_c1", 64'(pending), 64'd0);
    tick();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("t1_pending_c2", 64'(pending), 64'h4);
    chk("t1_we_c2", 64'(write_enable), 64'd0);
    tick();
    @(negedge clock);
    chk("t1_we_c3", 64'(write_enable), 64'd1);
    chk("t1_pending_c3", 64'(pending), 64'h4);
    tick();
    @(negedge clock);
    chk("t1_we_c4", 64'(write_enable), 64'd0);
    chk("t1_pending_c4", 64'(pending), 64'd0);

    // Simultaneous offers after reset: pointer favours requester 0
    do_reset();
    push(2'd1, 32'h11);
    push(2'd3, 32'h33);
    req0_valid = 1'b1; req0_register = 2'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_register = 2'd3; req1_data = 32'h33;
    @(negedge clock);
    chk("t2_ready0", 64'(req0_ready), 64'd1);
    chk("t2_ready1", 64'(req1_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    chk("t2_pending", 64'(pending), 64'hA);
    tick();
    @(negedge clock);
    chk("t2_we_first", 64'(write_enable), 64'd1);
    tick();
    @(negedge clock);
    chk("t2_we_second", 64'(write_enable), 64'd1);
    tick();
    @(negedge clock);
    chk("t2_we_idle", 64'(write_enable), 64'd0);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Older request to r0 commits first
    push(2'd0, 32'hAAAA);
    push(2'd0, 32'hBBBB);
    req1_valid = 1'b1; req1_register = 2'd0; req1_data = 32'hAAAA;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_register = 2'd0; req0_data = 32'hBBBB;
    @(negedge clock);
    chk("t3_ready0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clock);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // Both requesters streaming four writes each
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(2'd0, 32'(32'h100 + k));
      push(2'd1, 32'(32'h200 + k));
    end
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 12; c++) begin
      req0_valid = (i0 < 4); req0_register = 2'd0;
      req0_data  = 32'(32'h100 + i0);
      req1_valid = (i1 < 4); req1_register = 2'd1;
      req1_data  = 32'(32'h200 + i1);
      @(negedge clock);
      if (c >= 1 && c <= 6) begin
        chk($sformatf("t4_ready0_c%0d", c), 64'(req0_ready), 64'(c % 2));
        chk($sformatf("t4_ready1_c%0d", c), 64'(req1_ready),
            64'((c + 1) % 2));
      end
      if (c >= 2 && c <= 9)
        chk($sformatf("t4_we_c%0d", c), 64'(write_enable), 64'd1);
      if (c == 10)
        chk("t4_we_end", 64'(write_enable), 64'd0);
      if (req0_valid && req0_ready) i0++;
      if (req1_valid && req1_ready) i1++;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t4_req0_count", 64'(i0), 64'd4);
    chk("t4_req1_count", 64'(i1), 64'd4);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // Single requester streaming r0..r3 via replace-on-grant
    for (int k = 0; k < 4; k++) push(2'(k), 32'(32'h500 + k));
    for (int c = 0; c < 8; c++) begin
      req0_valid    = (c < 4);
      req0_register = 2'(c);
      req0_data     = 32'(32'h500 + c);
      @(negedge clock);
      if (c < 4)
        chk($sformatf("t5_ready0_c%0d", c), 64'(req0_ready), 64'd1);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("t5_we_c%0d", c), 64'(write_enable), 64'd1);
        chk($sformatf("t5_wreg_c%0d", c), 64'(write_register),
            64'(c - 2));
      end
      if (c == 6)
        chk("t5_we_end", 64'(write_enable), 64'd0);
      tick();
    end
    req0_valid = 1'b0;
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // Reset while both buffers hold writes: they are dropped
    req0_valid = 1'b1; req0_register = 2'd2; req0_data = 32'h66;
    req1_valid = 1'b1; req1_register = 2'd3; req1_data = 32'h77;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    chk("t6_ready0_in_reset", 64'(req0_ready), 64'd0);
    chk("t6_ready1_in_reset", 64'(req1_ready), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_pending", 64'(pending), 64'd0);
    chk("t6_we", 64'(write_enable), 64'd0);
    chk("t6_ready0", 64'(req0_ready), 64'd1);
    chk("t6_ready1", 64'(req1_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clock);
      chk($sformatf("t6_we_after_c%0d", c), 64'(write_enable), 64'd0);
    end

    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
